// File: rtl/nios_nios_oci_pkg.sv
// rtl/nios_nios_oci_pkg.sv - shared OCI trace widths and packer state encoding
//
// Purpose: constants shared by the DCT packer and the OCI FIFO stage.
//   PKG_SYM_W  : bits per trace symbol
//   PKG_SLOTS  : symbol slots per packed word
//   PKG_WORD_W : packed word width (PKG_SYM_W * PKG_SLOTS)
//   PKG_CNT_W  : width of a slot count (0..PKG_SLOTS)
//   ST_*       : packer FSM state encoding
package nios_nios_oci_pkg;

  localparam int PKG_SYM_W  = 2;
  localparam int PKG_SLOTS  = 15;
  localparam int PKG_WORD_W = PKG_SYM_W * PKG_SLOTS;
  localparam int PKG_CNT_W  = 4;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/nios_nios_oci_dct_outreg.sv
// rtl/nios_nios_oci_dct_outreg.sv - valid/ready holding register for packed trace words
//
// Purpose: holds one packed word and its symbol count for the downstream stage.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   load                    : capture load_buffer/load_count this cycle
//   load_buffer, load_count : word and count offered by the packer
//   out_ready               : downstream accepts the held word
//   out_valid               : held word is valid
//   dct_buffer, dct_count   : held word and count
module nios_nios_oci_dct_outreg
  import nios_nios_oci_pkg::*;
#(
  parameter int WORD_W = PKG_WORD_W,
  parameter int CNT_W  = PKG_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_buffer,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]  dct_count
);

  // The packer only asserts load when the register is free, so a load
  // always wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      dct_buffer <= load_buffer;
      dct_count  <= load_count;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_nios_oci_dct_packer.sv
// rtl/nios_nios_oci_dct_packer.sv - packs trace symbols into 30-bit DCT words with flush
//
// Purpose: accumulates SLOTS symbols of SYM_W bits into a word, hands full
// words (or a partial word on flush) to a holding register, then ends the trace.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid, in_sym      : offered trace symbol
//   in_ready              : symbol is accepted this cycle when in_valid
//   flush                 : request to drain the partial word and end the trace
//   out_ready             : downstream accepts the output word
//   out_valid             : dct_buffer/dct_count hold a valid word
//   dct_buffer, dct_count : packed word, number of valid symbols
//   test_ending           : flush is draining
//   test_has_ended        : flush completed, sticky until reset
module nios_nios_oci_dct_packer
  import nios_nios_oci_pkg::*;
#(
  parameter int SYM_W = PKG_SYM_W,
  parameter int SLOTS = PKG_SLOTS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_sym,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [SYM_W*SLOTS-1:0]   dct_buffer,
  output logic [PKG_CNT_W-1:0]     dct_count,
  output logic                     test_ending,
  output logic                     test_has_ended
);

  localparam int WORD_W = SYM_W * SLOTS;
  localparam logic [PKG_CNT_W-1:0] FULL = PKG_CNT_W'(SLOTS);

  logic [1:0]           state;
  logic [WORD_W-1:0]    acc;
  logic [WORD_W-1:0]    acc_ins;
  logic [PKG_CNT_W-1:0] acc_cnt;
  logic                 accept;
  logic                 out_free;
  logic                 xfer;

  always_comb begin
    in_ready = (state == ST_RUN) && (acc_cnt != FULL);
    accept   = in_valid && in_ready;
    out_free = !out_valid || out_ready;
    // In RUN only a full word moves; while flushing any non-empty remainder does.
    xfer     = out_free &&
               (((state == ST_RUN) && (acc_cnt == FULL)) ||
                ((state == ST_FLUSH) && (acc_cnt != '0)));
    acc_ins  = acc;
    for (int i = 0; i < SLOTS; i++) begin
      if (acc_cnt == PKG_CNT_W'(i)) begin
        acc_ins[i*SYM_W +: SYM_W] = in_sym;
      end
    end
  end

  // accept and xfer never coincide: RUN accepts only below FULL, FLUSH never accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      acc     <= '0;
      acc_cnt <= '0;
    end else begin
      if (xfer) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else if (accept) begin
        acc     <= acc_ins;
        acc_cnt <= acc_cnt + 1'b1;
      end
      case (state)
        ST_RUN:   if (flush) state <= ST_FLUSH;
        ST_FLUSH: if ((acc_cnt == '0) && !out_valid) state <= ST_DONE;
        ST_DONE:  state <= ST_DONE;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign test_ending    = (state == ST_FLUSH);
  assign test_has_ended = (state == ST_DONE);

  nios_nios_oci_dct_outreg #(
    .WORD_W (WORD_W),
    .CNT_W  (PKG_CNT_W)
  ) u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (xfer),
    .load_buffer (acc),
    .load_count  (acc_cnt),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count)
  );

endmodule
